i2c_reg_target: RTL and testbench
=================================

// Module: i2c_reg_target
// PURPOSE
//  I2C target (responder) with an internal byte-wide register file, answering the team's i2c_master on the shared
//  open-drain sda/scl bus. Supports 7-bit addressing, register-pointer write, multi-byte write/read with
//  pointer auto-increment, repeated START and optional clock stretching. Exposes a local write-event strobe and
//  a local read port so fabric logic can observe and consume register contents.
// PARAMETERS
//  slave_addr  7'h42  7-bit bus address this target answers to
//  depth       16     number of 8-bit registers; power of 2, 2..256
//  aw          4      log2(depth); pointer width
// PORTS
//  clk         in     1    system clock; 2-flop synchronisation requires clk >= 20x scl rate
//  rst         in     1    synchronous, active-high reset
//  sda         inout  1    I2C data; driven 1'b0 or 1'bz only, never 1
//  scl         inout  1    I2C clock; driven 1'b0 (stretch) or 1'bz only
//  stretch_en  in     1    when 1, hold scl low after each ACK/NACK bit until cleared
//  usr_addr    in     aw   local read address into register file
//  usr_rdata   out    8    register[usr_addr], registered, 1-cycle latency
//  wr_valid    out    1    1-cycle pulse: a bus write to a register was committed
//  wr_addr     out    aw   register index of that write; valid with wr_valid
//  wr_data     out    8    byte written; valid with wr_valid
//  busy        out    1    1 from matched address ACK until STOP, or START to another address
//  nack_seen   out    1    1-cycle pulse: master NACKed a read byte
// BEHAVIOUR
//  Reset: all registers 8'h00, pointer 0, sda/scl released (z), usr_rdata 0, wr_valid 0, busy 0, nack_seen 0,
//    FSM IDLE. Reset mid-transfer releases the bus immediately. Target ignores traffic until next START.
//  Input sync: sda/scl through 2 flops. Edges are detected on the synced values.
//    START = sda fall while scl high. STOP = sda rise while scl high.
//    Both are valid from any state and override everything else.
//  Sampling: sda is sampled on the scl rising edge.
//    Target changes sda only after the scl falling edge, within 3 clk of it.
//  FSM:
//    IDLE -> ADDR on START.
//    ADDR: shift 8 bits MSB-first (7 address bits + rw).
//    ADDR_ACK:
//      - match: drive ACK(0) for one scl pulse, busy=1; go to REG if rw=0, RDATA if rw=1.
//      - mismatch: leave sda released (NACK) and go to IDLE.
//    REG: shift 8 bits; pointer <= byte[aw-1:0] (upper bits ignored). REG_ACK drives ACK, then WDATA.
//    WDATA: shift 8 bits. On the 8th bit commit register[pointer], pulse wr_valid/wr_addr/wr_data,
//      pointer++. WDATA_ACK drives ACK, then WDATA.
//    RDATA: drive register[pointer] MSB-first; bit7 is presented after the ACK-phase scl fall.
//    RDATA_ACK: release sda and sample the master's bit.
//      - ACK(0): pointer++, back to RDATA.
//      - NACK(1): pulse nack_seen, go to WAIT (released) until STOP/START.
//  Pointer wraps depth-1 -> 0 on increment.
//  Repeated START: return to ADDR and keep the pointer. A write-then-read reads from the written pointer.
//  STOP: go to IDLE, busy=0, release sda. A partial byte is discarded with no commit.
//  Stretch: if stretch_en=1 at the scl falling edge ending any ACK/NACK bit, drive scl=0.
//    Release scl when stretch_en=0. Bit counting resumes on the next real scl rise.
//  Simultaneous bus write commit and usr_addr read of the same index: usr_rdata returns the old value,
//    and the new value the next cycle.
//  Bus read of a register returns the value committed before the byte's bit7 launch.
// STRUCTURE
//  i2c_defs.vh (shared include): FSM state encodings, ACK/NACK constants, sync depth.
//  Sub-module i2c_bus_sync: 2-flop sync of sda/scl plus scl_rise, scl_fall, start_det, stop_det pulses.
//  Register file: flop array inside i2c_reg_target. Open-drain drive via assign x = drv ? 1'b0 : 1'bz.
// TESTING (tb with pullups, i2c_master clk_freq=100e6, i2c_freq=100e3, slave_addr 7'h42)
//  1. Write: addr 0x42 W, reg 0x01, data 0xA5 -> 3 ACKs; wr_valid once with wr_addr=1, wr_data=A5;
//     usr_addr=1 gives usr_rdata=A5.
//  2. Read: reg 0x01 then repeated START, 0x42 R, master NACK -> read_data=A5, nack_seen pulse, busy=0 after STOP.
//  3. Burst write 0x0F: 11,22 -> reg15=11, reg0=22 (wrap). Burst read from 0x0F, 2 bytes -> 11, 22.
//  4. Address 7'h43 -> NACK on address bit, master ack_err=1, busy stays 0, no wr_valid, registers unchanged.
//  5. stretch_en=1 during write -> scl held low after address ACK for 500 clk. Transfer completes with
//     correct data, no ack_err.
//  6. rst pulse mid-data byte -> sda/scl released within 1 clk. The next full write to reg 0x02 succeeds.

Source files
------------

// File: rtl/i2c_reg_target_pkg.sv
// Shared types and constants for the I2C register target.
// State encodings, ACK levels and input synchroniser depth.
package i2c_reg_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_reg_target_bus_sync.sv
// Synchronises sda/scl into clk and derives bus events.
// START/STOP are sda edges seen while scl is stable high.
module i2c_bus_sync
  import i2c_reg_target_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sda_raw,
  input  logic scl_raw,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_DEPTH-1:0] sda_ff;
  logic [SYNC_DEPTH-1:0] scl_ff;
  logic                  sda_q;
  logic                  scl_q;
  logic                  scl_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_ff <= '1;
      scl_ff <= '1;
      sda_q  <= 1'b1;
      scl_q  <= 1'b1;
    end else begin
      sda_ff <= {sda_ff[SYNC_DEPTH-2:0], sda_raw};
      scl_ff <= {scl_ff[SYNC_DEPTH-2:0], scl_raw};
      sda_q  <= sda_ff[SYNC_DEPTH-1];
      scl_q  <= scl_ff[SYNC_DEPTH-1];
    end
  end

  assign sda_s     = sda_ff[SYNC_DEPTH-1];
  assign scl_s     = scl_ff[SYNC_DEPTH-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a byte-wide register file, pointer
// auto-increment, repeated START and optional clock stretching.
module i2c_reg_target
  import i2c_reg_target_pkg::*;
#(
  parameter logic [6:0] slave_addr = 7'h42,
  parameter int         depth      = 16,
  parameter int         aw         = 4
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire           sda,
  inout  wire           scl,
  input  logic          stretch_en,
  input  logic [aw-1:0] usr_addr,
  output logic [7:0]    usr_rdata,
  output logic          wr_valid,
  output logic [aw-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          nack_seen
);

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [6:0]    tx;
  logic [aw-1:0] ptr;
  logic [aw-1:0] nptr;
  logic          rw;
  logic          mbit;
  logic          sda_drv;
  logic          scl_drv;
  logic [7:0]    regs [depth];

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sda_raw   (sda),
    .scl_raw   (scl),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda  = sda_drv ? 1'b0 : 1'bz;
  assign scl  = scl_drv ? 1'b0 : 1'bz;
  assign nptr = ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) usr_rdata <= '0;
    else     usr_rdata <= regs[usr_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      mbit      <= NACK;
      sda_drv   <= 1'b0;
      scl_drv   <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      nack_seen <= 1'b0;
      for (int i = 0; i < depth; i++) regs[i] <= '0;
    end else begin
      wr_valid  <= 1'b0;
      nack_seen <= 1'b0;
      if (scl_drv && !stretch_en) scl_drv <= 1'b0;

      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_drv <= 1'b0;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        sda_drv <= 1'b0;
      end else if (scl_rise) begin
        unique case (state)
          ST_ADDR, ST_REG, ST_WDATA: begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end
          ST_RDATA:     bit_cnt <= bit_cnt + 4'd1;
          ST_RDATA_ACK: mbit <= sda_s;
          default: ;
        endcase
      end else if (scl_fall) begin
        // Byte-level decisions wait for the 8th fall so that a
        // STOP arriving mid-byte never commits anything.
        unique case (state)
          ST_ADDR: if (bit_cnt == 4'd8) begin
            if (shreg[7:1] == slave_addr) begin
              state   <= ST_ADDR_ACK;
              sda_drv <= 1'b1;
              busy    <= 1'b1;
              rw      <= shreg[0];
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          ST_REG: if (bit_cnt == 4'd8) begin
            ptr     <= shreg[aw-1:0];
            state   <= ST_REG_ACK;
            sda_drv <= 1'b1;
          end
          ST_WDATA: if (bit_cnt == 4'd8) begin
            regs[ptr] <= shreg;
            wr_valid  <= 1'b1;
            wr_addr   <= ptr;
            wr_data   <= shreg;
            ptr       <= nptr;
            state     <= ST_WDATA_ACK;
            sda_drv   <= 1'b1;
          end
          ST_RDATA: begin
            if (bit_cnt == 4'd8) begin
              state   <= ST_RDATA_ACK;
              sda_drv <= 1'b0;
            end else begin
              sda_drv <= ~tx[6];
              tx      <= {tx[5:0], 1'b0};
            end
          end
          ST_ADDR_ACK: begin
            bit_cnt <= '0;
            scl_drv <= stretch_en;
            if (rw) begin
              state   <= ST_RDATA;
              sda_drv <= ~regs[ptr][7];
              tx      <= regs[ptr][6:0];
            end else begin
              state   <= ST_REG;
              sda_drv <= 1'b0;
            end
          end
          ST_REG_ACK, ST_WDATA_ACK: begin
            bit_cnt <= '0;
            scl_drv <= stretch_en;
            sda_drv <= 1'b0;
            state   <= ST_WDATA;
          end
          ST_RDATA_ACK: begin
            bit_cnt <= '0;
            scl_drv <= stretch_en;
            if (mbit == NACK) begin
              nack_seen <= 1'b1;
              sda_drv   <= 1'b0;
              state     <= ST_WAIT;
            end else begin
              ptr     <= nptr;
              sda_drv <= ~regs[nptr][7];
              tx      <= regs[nptr][6:0];
              state   <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench: bus-functional I2C master with pullups
// driving i2c_reg_target at a fast scl for short runs.
module tb_i2c_reg_target;

  localparam int Q = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       stretch_en;
  logic [3:0] usr_addr;
  logic [7:0] usr_rdata;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       nack_seen;

  wire  sda;
  wire  scl;
  logic m_sda = 1'b1;
  logic m_scl = 1'b1;

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int nack_cnt = 0;
  logic [3:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  always #5 clk = ~clk;

  assign sda = m_sda ? 1'bz : 1'b0;
  assign scl = m_scl ? 1'bz : 1'b0;
  pullup (sda);
  pullup (scl);

  i2c_reg_target #(
    .slave_addr (7'h42),
    .depth      (16),
    .aw         (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sda        (sda),
    .scl        (scl),
    .stretch_en (stretch_en),
    .usr_addr   (usr_addr),
    .usr_rdata  (usr_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .nack_seen  (nack_seen)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (nack_seen) nack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
  endtask

  task automatic scl_up();
    int n;
    m_scl = 1'b1;
    n = 0;
    while (scl !== 1'b1 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) check("scl_timeout", 32'(scl), 1);
  endtask

  task automatic m_start();
    m_sda = 1'b1; wq();
    scl_up(); wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wq();
    scl_up(); wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic m_bit_tx(input logic b);
    m_sda = b; wq();
    scl_up(); wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic m_bit_rx(output logic b);
    m_sda = 1'b1; wq();
    scl_up(); wq();
    b = sda;
    m_scl = 1'b0; wq();
  endtask

  task automatic m_wbyte(input string tag, input logic [7:0] d,
                         input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) m_bit_tx(d[i]);
    m_bit_rx(a);
    check(tag, 32'(a), 32'(exp_ack));
  endtask

  task automatic m_rbyte(input logic nack, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      m_bit_rx(b);
      d = {d[6:0], b};
    end
    m_bit_tx(nack);
  endtask

  task automatic local_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk) usr_addr = a;
    @(negedge clk);
    d = usr_rdata;
  endtask

  initial begin
    logic [7:0] d;
    logic       b;
    int         w0;
    int         n0;
    int         lo;

    rst = 1'b1;
    stretch_en = 1'b0;
    usr_addr = '0;
    repeat (4) @(negedge clk);
    check("rst_rdata", 32'(usr_rdata), 0);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_nack", 32'(nack_seen), 0);
    check("rst_sda", 32'(sda), 1);
    check("rst_scl", 32'(scl), 1);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // single write: reg1 <= A5
    w0 = wr_cnt;
    m_start();
    m_wbyte("w1_addr_ack", 8'h84, 1'b0);
    check("w1_busy", 32'(busy), 1);
    m_wbyte("w1_reg_ack", 8'h01, 1'b0);
    m_wbyte("w1_data_ack", 8'hA5, 1'b0);
    m_stop();
    check("w1_wr_cnt", 32'(wr_cnt - w0), 1);
    check("w1_wr_addr", 32'(last_wa), 1);
    check("w1_wr_data", 32'(last_wd), 32'hA5);
    local_rd(4'd1, d);
    check("w1_local", 32'(d), 32'hA5);
    check("w1_busy_idle", 32'(busy), 0);

    // pointer write, repeated START, read with NACK
    n0 = nack_cnt;
    m_start();
    m_wbyte("r1_addr_ack", 8'h84, 1'b0);
    m_wbyte("r1_reg_ack", 8'h01, 1'b0);
    m_start();
    m_wbyte("r1_raddr_ack", 8'h85, 1'b0);
    m_rbyte(1'b1, d);
    check("r1_data", 32'(d), 32'hA5);
    check("r1_nack", 32'(nack_cnt - n0), 1);
    check("r1_busy_pre", 32'(busy), 1);
    m_stop();
    check("r1_busy_post", 32'(busy), 0);

    // burst write with pointer wrap 15 -> 0
    w0 = wr_cnt;
    m_start();
    m_wbyte("bw_addr_ack", 8'h84, 1'b0);
    m_wbyte("bw_reg_ack", 8'h0F, 1'b0);
    m_wbyte("bw_d0_ack", 8'h11, 1'b0);
    m_wbyte("bw_d1_ack", 8'h22, 1'b0);
    m_stop();
    check("bw_wr_cnt", 32'(wr_cnt - w0), 2);
    check("bw_last_addr", 32'(last_wa), 0);
    local_rd(4'd15, d);
    check("bw_reg15", 32'(d), 32'h11);
    local_rd(4'd0, d);
    check("bw_reg0", 32'(d), 32'h22);

    // burst read across the wrap
    m_start();
    m_wbyte("br_addr_ack", 8'h84, 1'b0);
    m_wbyte("br_reg_ack", 8'h0F, 1'b0);
    m_start();
    m_wbyte("br_raddr_ack", 8'h85, 1'b0);
    m_rbyte(1'b0, d);
    check("br_d0", 32'(d), 32'h11);
    m_rbyte(1'b1, d);
    check("br_d1", 32'(d), 32'h22);
    m_stop();

    // foreign address is NACKed and ignored
    w0 = wr_cnt;
    m_start();
    m_wbyte("na_addr_nack", 8'h86, 1'b1);
    check("na_busy", 32'(busy), 0);
    m_stop();
    check("na_wr_cnt", 32'(wr_cnt - w0), 0);
    local_rd(4'd1, d);
    check("na_reg1", 32'(d), 32'hA5);

    // clock stretch after the address ACK
    w0 = wr_cnt;
    lo = 0;
    stretch_en = 1'b1;
    fork
      begin
        m_start();
        m_wbyte("st_addr_ack", 8'h84, 1'b0);
        m_wbyte("st_reg_ack", 8'h03, 1'b0);
        m_wbyte("st_data_ack", 8'h5A, 1'b0);
        m_stop();
      end
      begin
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 20000) begin
          @(negedge clk); n++;
        end
        while (scl !== 1'b1 && n < 20000) begin
          @(negedge clk); n++;
        end
        while (scl !== 1'b0 && n < 20000) begin
          @(negedge clk); n++;
        end
        while (scl === 1'b0 && lo < 5000) begin
          @(negedge clk);
          lo++;
          if (lo == 500) stretch_en = 1'b0;
        end
        stretch_en = 1'b0;
      end
    join
    check("st_low_ok", 32'(lo >= 500 && lo <= 510), 1);
    check("st_wr_cnt", 32'(wr_cnt - w0), 1);
    local_rd(4'd3, d);
    check("st_reg3", 32'(d), 32'h5A);

    // reset while the target drives a read data bit
    m_start();
    m_wbyte("rr_addr_ack", 8'h84, 1'b0);
    m_wbyte("rr_reg_ack", 8'h00, 1'b0);
    m_start();
    m_wbyte("rr_raddr_ack", 8'h85, 1'b0);
    m_bit_rx(b);
    check("rr_bit7", 32'(b), 0);
    check("rr_drv", 32'(sda), 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("rr_sda_rel", 32'(sda), 1);
    check("rr_busy", 32'(busy), 0);
    rst = 1'b0;
    m_stop();
    local_rd(4'd15, d);
    check("rr_reg15_clr", 32'(d), 0);
    w0 = wr_cnt;
    m_start();
    m_wbyte("rw_addr_ack", 8'h84, 1'b0);
    m_wbyte("rw_reg_ack", 8'h02, 1'b0);
    m_wbyte("rw_data_ack", 8'h3C, 1'b0);
    m_stop();
    check("rw_wr_cnt", 32'(wr_cnt - w0), 1);
    check("rw_wr_addr", 32'(last_wa), 2);
    check("rw_wr_data", 32'(last_wd), 32'h3C);
    local_rd(4'd2, d);
    check("rw_reg2", 32'(d), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
